// File: rtl/layer_norm_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : layer_norm_stream_adapter
//  Purpose  : Streams x elements into the layer-norm core's flat vector, holds
//             the gamma/beta table, launches the core and streams y back out.
//  Revision : 1.0  initial release
// ============================================================================
module layer_norm_stream_adapter #(
    parameter int D_MODEL     = 64,
    parameter int X_WIDTH     = 16,
    parameter int Y_WIDTH     = 16,
    parameter int PARAM_WIDTH = 8,
    parameter int IDX_WIDTH   = 6
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [X_WIDTH-1:0]             s_data,
    input  logic                           s_last,

    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [Y_WIDTH-1:0]             m_data,
    output logic                           m_last,

    input  logic                           param_we,
    input  logic [IDX_WIDTH-1:0]           param_addr,
    input  logic [PARAM_WIDTH-1:0]         gamma_wdata,
    input  logic [PARAM_WIDTH-1:0]         beta_wdata,

    output logic                           ln_start,
    output logic [D_MODEL*X_WIDTH-1:0]     ln_x_flat,
    output logic [D_MODEL*PARAM_WIDTH-1:0] ln_gamma_flat,
    output logic [D_MODEL*PARAM_WIDTH-1:0] ln_beta_flat,
    input  logic                           ln_busy,
    input  logic                           ln_done,
    input  logic [D_MODEL*Y_WIDTH-1:0]     ln_y_flat,

    output logic                           len_err,
    output logic                           busy
);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(D_MODEL - 1);

    state_t                 r_state;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic [X_WIDTH-1:0]     r_x     [D_MODEL];
    logic [Y_WIDTH-1:0]     r_y     [D_MODEL];
    logic [PARAM_WIDTH-1:0] r_gamma [D_MODEL];
    logic [PARAM_WIDTH-1:0] r_beta  [D_MODEL];

    logic                   w_in_beat;
    logic                   w_out_beat;
    logic                   w_at_last;
    logic [IDX_WIDTH-1:0]   w_idx_inc;

    assign w_in_beat  = s_valid && s_ready;
    assign w_out_beat = m_valid && m_ready;
    assign w_at_last  = (r_idx == c_last_idx);
    assign w_idx_inc  = r_idx + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < D_MODEL; gi++) begin : g_flat
            assign ln_x_flat    [gi*X_WIDTH     +: X_WIDTH]     = r_x[gi];
            assign ln_gamma_flat[gi*PARAM_WIDTH +: PARAM_WIDTH] = r_gamma[gi];
            assign ln_beta_flat [gi*PARAM_WIDTH +: PARAM_WIDTH] = r_beta[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FILL;
            r_idx    <= '0;
            s_ready  <= 1'b1;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
            ln_start <= 1'b0;
            len_err  <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < D_MODEL; i++) begin
                r_x[i]     <= '0;
                r_y[i]     <= '0;
                r_gamma[i] <= '0;
                r_beta[i]  <= '0;
            end
        end else begin
            ln_start <= 1'b0;
            len_err  <= 1'b0;

            if (param_we) begin
                r_gamma[param_addr] <= gamma_wdata;
                r_beta[param_addr]  <= beta_wdata;
            end

            case (r_state)
                S_FILL: begin
                    if (w_in_beat) begin
                        r_x[r_idx] <= s_data;
                        if (w_at_last) begin
                            r_idx   <= '0;
                            s_ready <= 1'b0;
                            busy    <= 1'b1;
                            len_err <= !s_last;
                            // Launch straight from the final beat when the core is
                            // idle, so ln_start follows that beat by one cycle.
                            if (!ln_busy) begin
                                ln_start <= 1'b1;
                                r_state  <= S_WAIT;
                            end else begin
                                r_state  <= S_LAUNCH;
                            end
                        end else if (s_last) begin
                            r_idx   <= '0;
                            len_err <= 1'b1;
                        end else begin
                            r_idx   <= w_idx_inc;
                        end
                    end
                end

                S_LAUNCH: begin
                    if (!ln_busy) begin
                        ln_start <= 1'b1;
                        r_state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (ln_done) begin
                        for (int i = 0; i < D_MODEL; i++) begin
                            r_y[i] <= ln_y_flat[i*Y_WIDTH +: Y_WIDTH];
                        end
                        r_idx   <= '0;
                        m_valid <= 1'b1;
                        m_data  <= ln_y_flat[Y_WIDTH-1:0];
                        m_last  <= (c_last_idx == '0);
                        r_state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (w_out_beat) begin
                        if (w_at_last) begin
                            r_idx   <= '0;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_FILL;
                        end else begin
                            r_idx   <= w_idx_inc;
                            m_data  <= r_y[w_idx_inc];
                            m_last  <= (w_idx_inc == c_last_idx);
                        end
                    end
                end

                default: r_state <= S_FILL;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_norm_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_norm_stream_adapter
//  Purpose  : Scoreboard bench with a behavioural layer-norm core model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer_norm_stream_adapter;

    localparam int D  = 64;
    localparam int XW = 16;
    localparam int YW = 16;
    localparam int PW = 8;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              s_valid, s_ready, s_last;
    logic [XW-1:0]     s_data;
    logic              m_valid, m_ready, m_last;
    logic [YW-1:0]     m_data;
    logic              param_we;
    logic [IW-1:0]     param_addr;
    logic [PW-1:0]     gamma_wdata, beta_wdata;
    logic              ln_start, ln_busy, ln_done, len_err, busy;
    logic [D*XW-1:0]   ln_x_flat;
    logic [D*PW-1:0]   ln_gamma_flat, ln_beta_flat;
    logic [D*YW-1:0]   ln_y_flat;

    logic core_busy, ext_busy, core_done;
    assign ln_busy = core_busy | ext_busy;
    assign ln_done = core_done;

    layer_norm_stream_adapter #(
        .D_MODEL(D), .X_WIDTH(XW), .Y_WIDTH(YW), .PARAM_WIDTH(PW), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .param_we(param_we), .param_addr(param_addr),
        .gamma_wdata(gamma_wdata), .beta_wdata(beta_wdata),
        .ln_start(ln_start), .ln_x_flat(ln_x_flat),
        .ln_gamma_flat(ln_gamma_flat), .ln_beta_flat(ln_beta_flat),
        .ln_busy(ln_busy), .ln_done(ln_done), .ln_y_flat(ln_y_flat),
        .len_err(len_err), .busy(busy)
    );

    typedef struct packed {
        logic [YW-1:0] d;
        logic          l;
    } out_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state: parameter table, expected x frames, expected y stream.
    logic [PW-1:0]   g_m [D];
    logic [PW-1:0]   b_m [D];
    logic [D*XW-1:0] exp_x_q [$];
    out_t            sb [$];
    int exp_starts = 0, exp_lenerr = 0;
    int n_start = 0, n_lenerr = 0, last_start_cyc = 0, last_beat_cyc = 0;

    int core_delay = 5;
    int y_mode     = 0;
    bit core_stale = 0;
    bit core_idle  = 1;
    int rdy_mode   = 0;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/unexpected event, required normal completion", name);
    endtask

    function automatic logic [1023:0] pack_table(input bit beta);
        logic [1023:0] r;
        r = '0;
        for (int i = 0; i < D; i++) r[i*PW +: PW] = beta ? b_m[i] : g_m[i];
        return r;
    endfunction

    // Behavioural core: checks the launched operands, then returns a y vector.
    initial begin
        logic [D*XW-1:0] ex;
        logic [YW-1:0]   yv;
        core_busy = 1'b0;
        core_done = 1'b0;
        ln_y_flat = '0;
        forever begin
            @(negedge clk);
            if (!rst && ln_start) begin
                n_start++;
                last_start_cyc = cyc;
                if (exp_x_q.size() == 0) begin
                    fail_now("unexpected_ln_start");
                end else begin
                    ex = exp_x_q.pop_front();
                    check("ln_x_flat", ln_x_flat, ex);
                end
                check("ln_gamma_flat", ln_gamma_flat, pack_table(1'b0));
                check("ln_beta_flat", ln_beta_flat, pack_table(1'b1));
                core_idle = 0;
                core_busy = 1'b1;
                repeat (core_delay) @(negedge clk);
                for (int i = 0; i < D; i++) begin
                    yv = (y_mode == 0) ? YW'(i) : YW'($urandom);
                    ln_y_flat[i*YW +: YW] = yv;
                    if (!core_stale) sb.push_back('{d: yv, l: (i == D-1)});
                end
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
                core_busy = 1'b0;
                core_idle = 1;
            end
        end
    end

    // Output monitor: every presented element is compared to the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (len_err) n_lenerr++;
                if (m_valid) begin
                    if (sb.size() == 0) begin
                        fail_now("m_valid_unexpected");
                    end else begin
                        check("m_data", m_data, sb[0].d);
                        check("m_last", m_last, sb[0].l);
                        if (m_ready) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int k;
        k = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            k++;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k % 3) != 0;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_param(input int a, input logic [PW-1:0] g, input logic [PW-1:0] b);
        param_we    = 1'b1;
        param_addr  = IW'(a);
        gamma_wdata = g;
        beta_wdata  = b;
        tick();
        param_we    = 1'b0;
        g_m[a] = g;
        b_m[a] = b;
    endtask

    // Frame-level rule: only a D-element frame launches; any framing mismatch flags.
    task automatic send_frame(input int n, input int last_at, input int pat);
        logic [D*XW-1:0] fr;
        int guard;
        fr = '0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = (pat < 0) ? XW'($urandom) : XW'(pat);
            s_last  = (i == last_at);
            fr[i*XW +: XW] = s_data;
            guard = 0;
            forever begin
                @(negedge clk);
                if (s_ready) break;
                guard++;
                if (guard > 500) break;
            end
            if (guard > 500) fail_now("s_ready_timeout");
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        last_beat_cyc = cyc;
        if (n == D) begin
            exp_x_q.push_back(fr);
            exp_starts++;
            if (last_at != D-1) exp_lenerr++;
        end else begin
            exp_lenerr++;
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!(n_start == exp_starts && sb.size() == 0 && !busy && core_idle && !m_valid)) begin
            tick();
            g++;
            if (g > 3000) begin
                fail_now("idle_timeout");
                return;
            end
        end
        tick(2);
        check("start_count", n_start, exp_starts);
        check("len_err_count", n_lenerr, exp_lenerr);
        check("s_ready_idle", s_ready, 1);
    endtask

    task automatic check_reset_state();
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_ln_start", ln_start, 0);
        check("rst_len_err", len_err, 0);
        check("rst_busy", busy, 0);
        check("rst_ln_x_flat", ln_x_flat, 0);
        check("rst_ln_gamma_flat", ln_gamma_flat, 0);
        check("rst_ln_beta_flat", ln_beta_flat, 0);
    endtask

    initial begin
        int g;
        int fall_cyc;
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        param_we = 1'b0; param_addr = '0; gamma_wdata = '0; beta_wdata = '0;
        ext_busy = 1'b0;
        for (int i = 0; i < D; i++) begin g_m[i] = '0; b_m[i] = '0; end
        tick(3);
        check_reset_state();
        rst = 1'b0;
        tick(2);

        // Unit gamma, zero beta, constant x; y returns the element index.
        for (int a = 0; a < D; a++) write_param(a, 8'h40, 8'h00);
        y_mode = 0;
        send_frame(D, D-1, 16'h0400);
        tick();
        check("busy_after_launch", busy, 1);
        wait_idle();
        check("start_latency", last_start_cyc, last_beat_cyc);
        check("busy_idle", busy, 0);

        // 1-in-3 downstream stalls with random y.
        rdy_mode = 1;
        y_mode   = 1;
        send_frame(D, D-1, -1);
        wait_idle();
        rdy_mode = 0;

        // Early s_last discards the partial frame; next full frame launches.
        for (int j = 0; j < 4; j++) write_param(int'($urandom_range(0, D-1)), PW'($urandom), PW'($urandom));
        send_frame(11, 10, -1);
        wait_idle();
        send_frame(D, D-1, -1);
        wait_idle();

        // Missing s_last still launches; busy core postpones ln_start.
        send_frame(D, -1, -1);
        wait_idle();
        ext_busy = 1'b1;
        send_frame(D, D-1, -1);
        tick(20);
        check("no_start_while_busy", n_start, exp_starts - 1);
        ext_busy = 1'b0;
        fall_cyc = cyc;
        wait_idle();
        check("start_after_busy", last_start_cyc, fall_cyc + 1);

        // Reset during WAIT; the core's late ln_done must be ignored.
        rdy_mode   = 2;
        core_stale = 1;
        core_delay = 30;
        send_frame(D, D-1, -1);
        g = 0;
        while (n_start != exp_starts && g < 200) begin tick(); g++; end
        if (g >= 200) fail_now("start_timeout_before_reset");
        tick(3);
        check("busy_in_wait", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state();
        for (int i = 0; i < D; i++) begin g_m[i] = '0; b_m[i] = '0; end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        g = 0;
        while (!core_idle && g < 200) begin tick(); g++; end
        if (g >= 200) fail_now("stale_done_timeout");
        tick(5);
        check("stale_done_m_valid", m_valid, 0);
        check("stale_done_busy", busy, 0);
        core_stale = 0;
        core_delay = 3;
        send_frame(D, D-1, -1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, required summary before time limit");
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/layer_norm_stream_adapter.md
Name: layer_norm_stream_adapter

Overview:
- Hardware initiator for the layer-norm core. It plays the same role as that core's bench driver, but in synthesizable form.
- Serialises a stream of x elements into the flat vector, holds gamma/beta in a writable table, pulses start, waits for done, captures the flat y vector and streams it back out element by element.
- Sits between the token datapath (valid/ready streams) and layer_norm_top.

Parameters:
D_MODEL, 64, elements per vector
X_WIDTH, 16, input element width (Q5.10)
Y_WIDTH, 16, output element width (Q5.10)
PARAM_WIDTH, 8, gamma/beta width (Q1.6)
IDX_WIDTH, 6, index width, equal to clog2(D_MODEL)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
s_valid  in  1  input element valid
s_ready  out  1  adapter accepts input element
s_data  in  X_WIDTH  input element, signed
s_last  in  1  marks final element of a vector
m_valid  out  1  output element valid
m_ready  in  1  downstream accepts output element
m_data  out  Y_WIDTH  output element, signed
m_last  out  1  marks element D_MODEL-1 on output
param_we  in  1  write strobe for gamma/beta table
param_addr  in  IDX_WIDTH  table index
gamma_wdata  in  PARAM_WIDTH  gamma value
beta_wdata  in  PARAM_WIDTH  beta value
ln_start  out  1  one-cycle start pulse to core
ln_x_flat  out  D_MODEL*X_WIDTH  x vector; element i at bits [i*X_WIDTH +: X_WIDTH]
ln_gamma_flat  out  D_MODEL*PARAM_WIDTH  gamma table, same packing
ln_beta_flat  out  D_MODEL*PARAM_WIDTH  beta table, same packing
ln_busy  in  1  core busy
ln_done  in  1  core done_valid
ln_y_flat  in  D_MODEL*Y_WIDTH  core result
len_err  out  1  one-cycle pulse on framing error
busy  out  1  high in every state except FILL

Behaviour:
- Reset (asynchronous, rst=1) sets:
  - state=FILL and idx=0;
  - s_ready=1, m_valid=0, m_last=0, m_data=0, ln_start=0, len_err=0, busy=0;
  - x buffer, y buffer, gamma and beta all to 0.
  - Reset mid-operation abandons any frame in progress. ln_start is never reissued for it.
- The gamma/beta table is written when param_we=1, in any state. The write is visible on ln_*_flat the next cycle. Software must not write while busy=1; such writes still take effect, but their use by the core is undefined.
- FILL:
  - s_ready=1.
  - On an s_valid&&s_ready beat, s_data is stored to x[idx] and idx increments.
  - Beat at idx=D_MODEL-1:
    - go to LAUNCH, idx cleared;
    - if s_last=0, pulse len_err, but the frame still proceeds.
  - Beat with s_last=1 at idx<D_MODEL-1:
    - pulse len_err, stay in FILL, idx cleared;
    - the partial frame is discarded. Buffer contents are overwritten by the next frame.
- LAUNCH:
  - s_ready=0.
  - While ln_busy=1, wait.
  - When ln_busy=0, assert ln_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On ln_done=1, capture ln_y_flat into the y buffer and go to DRAIN with idx=0.
  - ln_done in any other state is ignored.
- DRAIN:
  - m_valid=1, m_data=y[idx], m_last=(idx==D_MODEL-1).
  - On m_valid&&m_ready, idx increments.
  - On the last beat, go to FILL, idx=0, and s_ready rises the next cycle.
  - m_data and m_last are stable while m_valid=1 and m_ready=0.
- Latency:
  - last input beat to ln_start: 1 cycle when ln_busy=0;
  - ln_done to first m_valid: 1 cycle;
  - output throughput is 1 element per cycle with m_ready held high.
- ln_x_flat reflects the x buffer continuously. It is held constant from LAUNCH until the next FILL beat.
- No arithmetic is performed. Elements pass bit-exact in both directions.

Test Plan:
1. Write gamma=0x40, beta=0x00 for all 64 indices. Stream 64 x of 0x0400 with s_last on element 63 -> one ln_start pulse one cycle after the last beat; ln_x_flat holds 64 copies of 0x0400.
2. Model the core returning y element i = i (16-bit). With m_ready=1 -> m_data sequence 0..63, m_last only on 63, then s_ready=1.
3. Toggle m_ready with a 1-in-3 pattern -> no element lost or duplicated; m_data stable while stalled.
4. Assert s_last on element 10 -> len_err pulse, no ln_start. A following full 64-element frame launches normally with only new data.
5. Send 64 elements without s_last -> len_err pulse and ln_start still issued. Hold ln_busy=1 for 20 cycles at launch -> ln_start delayed until ln_busy falls.
6. Assert rst during WAIT, then send a complete frame after release -> all outputs at reset values, and the stale ln_done is ignored.
